// File: rtl/idma_burst_sink_pkg.sv
// Shared types and helpers for the burst sink: default request layout,
// FSM state encoding and the beat-count calculation.
package idma_burst_sink_pkg;

  localparam int unsigned PkgAddrWidth = 64;
  localparam int unsigned PkgLenWidth  = 32;

  typedef struct packed {
    logic [PkgAddrWidth-1:0] src_addr;
    logic [PkgAddrWidth-1:0] dst_addr;
    logic [PkgLenWidth-1:0]  length;
  } burst_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Beats needed to retire len bytes at 2**log2_bpc bytes per cycle.
  // Evaluated in 64 bits so the rounding add cannot overflow for any
  // length field up to 62 bits. A zero-length request still costs one beat.
  function automatic logic [63:0] calc_beats(input logic [63:0] len,
                                             input int unsigned log2_bpc);
    logic [63:0] round_up;
    logic [63:0] beats;
    round_up = (64'd1 << log2_bpc) - 64'd1;
    beats    = (len + round_up) >> log2_bpc;
    if (beats == 64'd0) begin
      beats = 64'd1;
    end
    return beats;
  endfunction

endpackage

// File: rtl/idma_burst_sink_fifo.sv
// Request buffer: wrap-around read/write pointers plus an occupancy
// counter. Pushes while full and pops while empty are ignored; a push and
// a pop in the same cycle leave the occupancy unchanged.
module idma_burst_sink_fifo #(
  parameter int unsigned Depth = 4,
  parameter type T = logic
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  T                    r_mem [Depth];
  logic [PtrWidth-1:0] r_wr_ptr;
  logic [PtrWidth-1:0] r_rd_ptr;
  logic [CntWidth-1:0] r_count;
  logic                w_push;
  logic                w_pop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    if (ptr == PtrWidth'(Depth - 1)) begin
      return '0;
    end
    return ptr + PtrWidth'(1);
  endfunction

  assign o_full  = (r_count == CntWidth'(Depth));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage is written only on an accepted push; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntWidth'(1);
        2'b01:   r_count <= r_count - CntWidth'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/idma_burst_sink.sv
// Stand-in for the iDMA backend: buffers burst requests, spends
// ceil(length / BytesPerCycle) active cycles on each, then pulses
// tx_complete_o for one cycle and counts the completion.
//
// Handshake: a request transfers on a rising clk edge where burst_valid_i
// and burst_ready_o are both high. burst_ready_o depends only on reset and
// FIFO fullness, never on burst_valid_i, and a same-cycle pop does not
// open a full FIFO.
module idma_burst_sink #(
  parameter int unsigned BytesPerCycle = 8,
  parameter int unsigned LenWidth      = 32,
  parameter int unsigned FifoDepth     = 4,
  parameter type burst_req_t = idma_burst_sink_pkg::burst_req_t
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  burst_req_t                  burst_req_i,
  input  logic                        burst_valid_i,
  output logic                        burst_ready_o,
  input  logic                        stall_i,
  output logic                        tx_complete_o,
  output logic                        idle_o,
  output logic [31:0]                 completed_cnt_o,
  output idma_burst_sink_pkg::state_e dbg_state_o
);

  import idma_burst_sink_pkg::*;

  if (BytesPerCycle == 0 || (BytesPerCycle & (BytesPerCycle - 1)) != 0) begin : g_bad_bpc
    $error("BytesPerCycle must be a power of two and at least 1");
  end
  if (FifoDepth == 0) begin : g_bad_depth
    $error("FifoDepth must be at least 1");
  end
  if (LenWidth == 0 || LenWidth > 62) begin : g_bad_len
    $error("LenWidth must be between 1 and 62");
  end

  localparam int unsigned Log2Bpc  = $clog2(BytesPerCycle);
  localparam int unsigned CntWidth = LenWidth + 1;

  state_e              r_state;
  state_e              w_state_next;
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] w_beats;
  logic [31:0]         r_completed;
  logic                w_push;
  logic                w_pop;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  burst_req_t          w_head;

  assign burst_ready_o = !rst_i && !w_fifo_full;
  assign w_push        = burst_valid_i && burst_ready_o;

  idma_burst_sink_fifo #(
    .Depth (FifoDepth),
    .T     (burst_req_t)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_data  (burst_req_i),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Beat count of the request at the FIFO head, loaded on every pop.
  assign w_beats = CntWidth'(calc_beats(64'(w_head.length), Log2Bpc));

  // Next-state and pop decision; stall only matters while transferring.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!stall_i && r_cnt == CntWidth'(1)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_XFER;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Remaining beats of the request in flight; frozen while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= w_beats;
    end else if (r_state == ST_XFER && !stall_i) begin
      r_cnt <= r_cnt - CntWidth'(1);
    end
  end

  // DONE lasts exactly one cycle, so count on every DONE cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_completed <= '0;
    end else if (r_state == ST_DONE) begin
      r_completed <= r_completed + 32'd1;
    end
  end

  assign tx_complete_o   = (r_state == ST_DONE);
  assign idle_o          = (r_state == ST_IDLE) && w_fifo_empty;
  assign completed_cnt_o = r_completed;
  assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_idma_burst_sink.sv
// Directed bench for idma_burst_sink: latency, beat rounding, back-to-back
// throughput with backpressure, stall, and reset during a transfer.
module tb_idma_burst_sink;

  import idma_burst_sink_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  burst_req_t  req;
  logic        valid;
  logic        ready;
  logic        stall;
  logic        tx;
  logic        idle;
  logic [31:0] cnt;
  state_e      dbg;

  burst_req_t  b_req;
  logic        b_valid;
  logic        b_ready;
  logic        b_tx;
  logic        b_idle;
  logic [31:0] b_cnt;
  state_e      b_dbg;

  idma_burst_sink u_dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .burst_req_i     (req),
    .burst_valid_i   (valid),
    .burst_ready_o   (ready),
    .stall_i         (stall),
    .tx_complete_o   (tx),
    .idle_o          (idle),
    .completed_cnt_o (cnt),
    .dbg_state_o     (dbg)
  );

  // Wide-beat instance: lets a maximum-length request finish quickly
  // while still exercising the rounding overflow path.
  idma_burst_sink #(
    .BytesPerCycle (1 << 20)
  ) u_big (
    .clk_i           (clk),
    .rst_i           (rst),
    .burst_req_i     (b_req),
    .burst_valid_i   (b_valid),
    .burst_ready_o   (b_ready),
    .stall_i         (1'b0),
    .tx_complete_o   (b_tx),
    .idle_o          (b_idle),
    .completed_cnt_o (b_cnt),
    .dbg_state_o     (b_dbg)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_cnt;
  logic [31:0] exp_q[$];
  logic [31:0] t2_len [4] = '{32'd0, 32'd1, 32'd8, 32'd9};
  int          t2_exp [4] = '{2, 2, 2, 3};
  int          acc;
  int          pulses;
  int          n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request; returns just after its accepting edge (edge 0).
  task automatic send(input logic [31:0] len, input string tag);
    req.length = len;
    valid      = 1'b1;
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    step();
    valid = 1'b0;
  endtask

  // Wait for a completion pulse exp_steps edges from now, then check it
  // lasts one cycle and bumps the completion counter.
  task automatic wait_pulse(input int exp_steps, input string tag);
    int k;
    k = 0;
    while (tx !== 1'b1 && k < exp_steps + 20) begin
      step();
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'(exp_steps));
    exp_cnt = exp_cnt + 32'd1;
    step();
    chk({tag, "_one_cycle"}, 64'(tx), 64'd0);
    chk({tag, "_count"}, 64'(cnt), 64'(exp_cnt));
  endtask

  // Keep valid high until n_req requests have been accepted; every pulse
  // must land on the step index at the head of exp_q.
  task automatic run_window(input int n_req, input int acc_start, input int steps,
                            input string tag);
    int a;
    a = acc_start;
    for (int j = 1; j <= steps; j++) begin
      if (valid && ready) a++;
      step();
      if (a >= n_req) valid = 1'b0;
      if (tx === 1'b1) begin
        exp_cnt = exp_cnt + 32'd1;
        if (exp_q.size() > 0) chk({tag, "_pulse_step"}, 64'(j), 64'(exp_q.pop_front()));
        else chk({tag, "_extra_pulse"}, 64'(j), 64'd0);
      end
    end
    chk({tag, "_missing_pulses"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_accepted"}, 64'(a), 64'(n_req));
    chk({tag, "_count"}, 64'(cnt), 64'(exp_cnt));
    chk({tag, "_idle"}, 64'(idle), 64'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst     = 1'b1;
    valid   = 1'b0;
    stall   = 1'b0;
    req     = '0;
    b_valid = 1'b0;
    b_req   = '0;
    exp_cnt = 32'd0;

    // Reset state
    step();
    step();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_tx", 64'(tx), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(ready), 64'd1);

    // Length 64 -> 8 beats, pulse between edges 9 and 10
    send(32'd64, "t1");
    chk("t1_idle_low", 64'(idle), 64'd0);
    wait_pulse(9, "t1");
    chk("t1_idle_back", 64'(idle), 64'd1);

    // Beat rounding: 0,1,8,9 bytes -> 1,1,1,2 beats
    for (int i = 0; i < 4; i++) begin
      send(t2_len[i], "t2");
      wait_pulse(t2_exp[i], $sformatf("t2_len%0d", t2_len[i]));
    end

    // Stall in IDLE and DONE must not change transitions
    stall = 1'b1;
    send(32'd8, "t2s");
    step();
    chk("t2s_idle_pop_under_stall", 64'(dbg), 64'(ST_XFER));
    stall = 1'b0;
    step();
    chk("t2s_done", 64'(tx), 64'd1);
    stall = 1'b1;
    step();
    exp_cnt = exp_cnt + 32'd1;
    chk("t2s_done_exit_under_stall", 64'(dbg), 64'(ST_IDLE));
    chk("t2s_idle", 64'(idle), 64'd1);
    chk("t2s_count", 64'(cnt), 64'(exp_cnt));
    stall = 1'b0;

    // Maximum length on the wide-beat instance: 2^32-1 bytes -> 4096 beats
    b_req.length = 32'hFFFF_FFFF;
    b_valid      = 1'b1;
    chk("big_ready", 64'(b_ready), 64'd1);
    step();
    b_valid = 1'b0;
    n = 0;
    while (b_tx !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    chk("big_latency", 64'(n), 64'd4097);
    step();
    chk("big_count", 64'(b_cnt), 64'd1);
    chk("big_idle", 64'(b_idle), 64'd1);
    chk("big_state", 64'(b_dbg), 64'(ST_IDLE));

    // Stall for 3 cycles mid-XFER: length 32 -> pulse at edge 8 not 5
    send(32'd32, "t4");
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_hold_state", 64'(dbg), 64'(ST_XFER));
      chk("t4_no_pulse", 64'(tx), 64'd0);
    end
    stall = 1'b0;
    wait_pulse(3, "t4");

    // Six length-8 requests with the first one stalled: FIFO fills to 4
    stall      = 1'b1;
    req.length = 32'd8;
    valid      = 1'b1;
    acc        = 0;
    for (int i = 0; i < 5; i++) begin
      if (ready) acc++;
      step();
    end
    chk("t3_accepted_before_full", 64'(acc), 64'd5);
    chk("t3_full_ready", 64'(ready), 64'd0);
    step();
    step();
    chk("t3_full_hold", 64'(ready), 64'd0);
    chk("t3_no_pulse", 64'(tx), 64'd0);
    stall = 1'b0;
    step();
    exp_cnt = exp_cnt + 32'd1;
    chk("t3_first_pulse", 64'(tx), 64'd1);
    chk("t3_no_passthrough", 64'(ready), 64'd0);
    exp_q = '{32'd2, 32'd4, 32'd6, 32'd8, 32'd10};
    run_window(6, 5, 14, "t3");

    // Three back-to-back requests: pushes coincide with pops
    req.length = 32'd8;
    valid      = 1'b1;
    exp_q = '{32'd3, 32'd5, 32'd7};
    run_window(3, 0, 10, "t6");

    // Reset during XFER with two requests buffered
    req.length = 32'hFFFF_FFFF;
    valid      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    req.length = 32'd8;
    valid      = 1'b0;
    step();
    step();
    chk("t5_in_xfer", 64'(dbg), 64'(ST_XFER));
    chk("t5_busy", 64'(idle), 64'd0);
    rst = 1'b1;
    step();
    chk("t5_rst_idle", 64'(idle), 64'd1);
    chk("t5_rst_cnt", 64'(cnt), 64'd0);
    chk("t5_rst_ready", 64'(ready), 64'd0);
    rst     = 1'b0;
    exp_cnt = 32'd0;
    pulses  = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tx === 1'b1) pulses++;
    end
    chk("t5_dropped_no_pulse", 64'(pulses), 64'd0);
    chk("t5_idle_after", 64'(idle), 64'd1);
    send(32'd64, "t5_new");
    wait_pulse(9, "t5_new");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idma_burst_sink.md
# idma_burst_sink

Synthesizable backend model that terminates the burst-request interface a descriptor frontend drives toward the iDMA backend. It accepts `burst_req_t` requests through a valid/ready handshake and buffers them in a FIFO. Each request is then "executed" for a length-derived number of cycles, and the block reports completion through the same `tx_complete` / `idle` signals the frontend consumes. It sits in place of the real backend in frontend-only synthesis and test harnesses.

## Interface
- `BytesPerCycle`, default 8: bytes retired per active cycle; power of two, at least 1 (elaboration assertion).
- `LenWidth`, default 32: width of the `length` field of `burst_req_t`.
- `FifoDepth`, default 4: request buffer entries; at least 1.
- `burst_req_t`, default `idma_burst_sink_pkg::burst_req_t`: request type; must contain field `length` of `LenWidth` bits. No other fields are interpreted.
- `clk_i`, input, 1: clock; single clock domain.
- `rst_i`, input, 1: reset; synchronous, active-high.
- `burst_req_i`, input, `burst_req_t`: request payload.
- `burst_valid_i`, input, 1: request valid.
- `burst_ready_o`, output, 1: request accepted on a clock edge where both valid and ready are high.
- `stall_i`, input, 1: freezes beat retirement while high (models backpressure).
- `tx_complete_o`, output, 1: one-cycle pulse per finished request, in acceptance order.
- `idle_o`, output, 1: no request buffered or executing.
- `completed_cnt_o`, output, 32: number of completed requests; wraps at 2^32.

## Operation
- Beat count N = ceil(length / BytesPerCycle). Computed as (length + BytesPerCycle-1) >> log2(BytesPerCycle) in LenWidth+1 bits, so the maximum length does not overflow. length = 0 gives N = 1.
- `burst_ready_o` = !rst_i && !fifo_full. It is combinational and does not depend on `burst_valid_i`. A pop in the same cycle does not raise ready when the FIFO is full; there is no pass-through.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head, load cnt = N, and go to XFER.
  - XFER: when !stall_i, decrement cnt. At the edge where cnt == 1 && !stall_i, go to DONE. While stall_i is high, hold state and cnt.
  - DONE: `tx_complete_o` = 1 (Moore output). `completed_cnt_o` increments at the edge leaving DONE. If the FIFO is non-empty, pop, load N and go to XFER; otherwise go to IDLE.
- `idle_o` = (state == IDLE) && fifo_empty. It is not gated by `burst_valid_i`.
- FIFO push and pop in the same cycle are both honoured; occupancy is unchanged.
- A stall asserted in IDLE or DONE has no effect on transitions. It only affects XFER.
- Reset, including mid-transfer: FIFO cleared, state IDLE, cnt 0, `completed_cnt_o` 0. Any in-flight or buffered requests are dropped and produce no completion.

## Timing
- Reset values:
  - `burst_ready_o` = 0 while `rst_i` is high, 1 from the first cycle after it.
  - `tx_complete_o` = 0.
  - `idle_o` = 1.
  - `completed_cnt_o` = 0.
- Latency with no stall, request accepted at edge 0 into an empty FIFO in IDLE:
  - pop at edge 1;
  - XFER for N cycles (edges 2..N+1);
  - `tx_complete_o` high between edges N+1 and N+2.
- Back-to-back throughput: N+1 cycles per request, meaning one DONE cycle between consecutive XFER phases. Each stalled XFER cycle adds one cycle.
- `idle_o` falls in the cycle after the accepting edge, because the FIFO becomes non-empty. It rises in the cycle after the final DONE when the FIFO is empty.

## Structure
- Package `idma_burst_sink_pkg`:
  - default `burst_req_t` (fields `length`, `src_addr`, `dst_addr`; AddrWidth 64, LenWidth 32);
  - FSM state enum {IDLE, XFER, DONE};
  - beat-count function.
- Sub-module `idma_burst_sink_fifo`:
  - parameterised depth and type;
  - synchronous active-high reset;
  - full/empty flags;
  - wrap-around read/write pointers plus occupancy counter.
- Top level holds the FSM, beat counter and completion counter only.

## Test plan
- Reset then one request, length 64, BytesPerCycle 8, no stall → N = 8; accepted at edge 0, `tx_complete_o` high exactly between edges 9 and 10; `completed_cnt_o` = 1; `idle_o` back to 1.
- Lengths 0, 1, 8, 9 and 2^32-1 → N = 1, 1, 1, 2, 2^29; each request produces exactly one pulse.
- Push 6 requests of length 8 with valid held high, FifoDepth 4 → `burst_ready_o` drops once the FIFO holds 4 entries; all 6 pulses arrive in order, spaced 2 cycles apart.
- Length 32 with `stall_i` high for 3 cycles mid-XFER → the pulse arrives 3 cycles later than the no-stall case; cnt is held during the stall.
- Reset asserted during XFER with 2 requests buffered → no pulse; `idle_o` = 1 and `completed_cnt_o` = 0 after reset; a new request completes with nominal latency.
- Push in the same cycle as a DONE pop with the FIFO full → occupancy unchanged; no request lost or duplicated.
